instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage sitting directly upstream of the opcode decoder. Holds the PC and fetches
//  one instruction at a time from instruction memory over a req/ack handshake.
//  Presents instr[31:26] to the decoder and retires the instruction when the datapath
//  accepts it. Resolves next PC from decoder outputs beq/bne/jump plus ALU zero.
// PARAMETERS
//  ADDR_W    32            PC / memory address width
//  RESET_PC  32'h0000_0000 PC value loaded on reset (word aligned)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  imem_req     out  1       fetch request; imem_addr valid while high
//  imem_addr    out  ADDR_W  fetch address (= pc)
//  imem_ack     in   1       read data valid this cycle
//  imem_rdata   in   32      instruction word
//  instr        out  32      registered instruction to decode/datapath
//  instr_valid  out  1       instr holds an unretired instruction
//  instr_ready  in   1       datapath accepts instr this cycle (retire)
//  beq, bne, jump in 1 each  decoder outputs for current instr
//  alu_zero     in   1       ALU zero flag for current instr
//  pc           out  ADDR_W  PC of current instr
//  pc_plus4     out  ADDR_W  pc + 4 (combinational)
//  retired_cnt  out  32      retired-instruction counter
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, instr=0, instr_valid=0, imem_req=0,
//   retired_cnt=0, state=S_BOOT. Reset mid-fetch abandons the request immediately.
//  FSM: S_BOOT -> S_FETCH unconditionally on first clk edge with rst_n=1.
//   S_FETCH: imem_req=1, imem_addr=pc held stable. On imem_ack: instr<=imem_rdata,
//    instr_valid<=1, go S_HOLD (req low next cycle). Ack in same cycle as req allowed.
//   S_HOLD: instr_valid=1, imem_req=0. On instr_ready: pc<=npc, instr_valid<=0,
//    retired_cnt<=retired_cnt+1, go S_FETCH.
//  Latency: req->ack(cycle N) => instr_valid at N+1; retire(cycle M) => req at M+1.
//  imem_ack outside S_FETCH ignored. instr_ready outside S_HOLD ignored.
//  beq/bne/jump/alu_zero sampled only on retire cycle.
//  npc priority: jump -> {pc_plus4[31:28], instr[25:0], 2'b00};
//   else taken branch (beq&alu_zero | bne&~alu_zero) -> pc_plus4 + (sext(instr[15:0])<<2);
//   else pc_plus4. beq&bne both high: taken if either condition holds.
//  Arithmetic modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0. pc[1:0] always 2'b00.
//  retired_cnt wraps 32'hFFFF_FFFF -> 0.
// STRUCTURE
//  Shared package: fetch state encoding (S_BOOT,S_FETCH,S_HOLD), npc-select constants
//   (NPC_SEQ,NPC_BR,NPC_JMP), default RESET_PC.
//  One sub-module: next_pc_logic (combinational: pc, instr, beq, bne, jump, alu_zero -> npc).
// TESTING
//  1 Reset: rst_n low mid-S_FETCH -> imem_req=0, pc=RESET_PC, instr_valid=0 immediately;
//    release -> req at pc=0 after one S_BOOT cycle.
//  2 Sequential: zero-wait ack, instr_ready=1 each HOLD -> addrs 0,4,8; retired_cnt=3.
//  3 Branch: pc=0x40, beq=1, alu_zero=1, imm=16'hFFFE -> next imem_addr=0x3C;
//    alu_zero=0 -> 0x44; bne=1, alu_zero=0, imm=3 -> 0x50.
//  4 Jump: pc=0x1000_0010, jump=1, instr[25:0]=26'h000_0040 -> imem_addr=0x1000_0100,
//    jump wins with beq=1, alu_zero=1.
//  5 Stalls: ack after 3 cycles, instr_ready after 2 -> imem_addr stable, instr stable,
//    no double retire, stray ack in S_HOLD ignored.
//  6 Wrap: pc=32'hFFFF_FFFC sequential retire -> imem_addr=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: fetch FSM encoding, next-PC select codes and default reset PC
package instr_fetch_unit_pkg;
  localparam logic [1:0] S_BOOT = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2;
  localparam logic [1:0] NPC_SEQ = 2'd0, NPC_BR = 2'd1, NPC_JMP = 2'd2;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory, decoder and datapath signals around the fetch stage
interface instr_fetch_unit_if #(parameter int ADDR_W = 32);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              beq;
  logic              bne;
  logic              jump;
  logic              alu_zero;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [31:0]       retired_cnt;
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, retired_cnt,
    input  imem_ack, imem_rdata, instr_ready, beq, bne, jump, alu_zero
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, retired_cnt,
    output imem_ack, imem_rdata, instr_ready, beq, bne, jump, alu_zero
  );
endinterface

// File: rtl/instr_fetch_unit_next_pc_logic.sv
// next_pc_logic: resolves the next PC from jump/branch decode and the ALU zero flag
module next_pc_logic
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [25:0]       instr_i,
  input  logic              beq_i,
  input  logic              bne_i,
  input  logic              jump_i,
  input  logic              alu_zero_i,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [ADDR_W-1:0] npc_o
);
  logic [1:0]        sel;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;
  always_comb begin
    pc_plus4_o = pc_i + ADDR_W'(4);
    br_tgt     = pc_plus4_o + {{(ADDR_W-18){instr_i[15]}}, instr_i[15:0], 2'b00};
    jmp_tgt    = {pc_plus4_o[ADDR_W-1 -: ADDR_W-28], instr_i, 2'b00};
    // beq and bne together act as an OR of both branch conditions
    sel        = jump_i ? NPC_JMP
               : ((beq_i & alu_zero_i) | (bne_i & ~alu_zero_i)) ? NPC_BR : NPC_SEQ;
    npc_o      = sel == NPC_JMP ? jmp_tgt : sel == NPC_BR ? br_tgt : pc_plus4_o;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the PC, fetches one instruction at a time and retires it to the datapath
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_fetch_unit_if.master  bus
);
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, npc;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              ack_hit, retire;
  next_pc_logic #(.ADDR_W(ADDR_W)) u_npc (
    .pc_i       (pc_q),
    .instr_i    (instr_q[25:0]),
    .beq_i      (bus.beq),
    .bne_i      (bus.bne),
    .jump_i     (bus.jump),
    .alu_zero_i (bus.alu_zero),
    .pc_plus4_o (bus.pc_plus4),
    .npc_o      (npc)
  );
  always_comb begin
    ack_hit = state_q == S_FETCH && bus.imem_ack;
    retire  = state_q == S_HOLD && bus.instr_ready;
    state_d = state_q == S_BOOT ? S_FETCH : ack_hit ? S_HOLD : retire ? S_FETCH : state_q;
    pc_d    = retire ? npc : pc_q;
    instr_d = ack_hit ? bus.imem_rdata : instr_q;
    valid_d = ack_hit | (valid_q & ~retire);
    cnt_d   = cnt_q + 32'(retire);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.imem_req    = state_q == S_FETCH;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized fetch/retire traffic checked against a PC/retire-count reference model
module tb_instr_fetch_unit;
  logic clk;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  instr_fetch_unit_if #(.ADDR_W(32)) bus ();
  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [31:0] w,
                                          input logic b_eq, input logic b_ne, input logic jmp, input logic z);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (jmp) return (seq & 32'hF000_0000) | ({6'd0, w[25:0]} << 2);
    if ((b_eq && z) || (b_ne && !z)) return seq + int'($signed(w[15:0])) * 4;
    return seq;
  endfunction

  task automatic idle_inputs();
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;
    bus.beq = 1'b0;
    bus.bne = 1'b0;
    bus.jump = 1'b0;
    bus.alu_zero = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.pc !== 32'h0 || bus.instr_valid !== 1'b0 ||
        bus.instr !== 32'h0 || bus.retired_cnt !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: req=%b pc=%h valid=%b instr=%h cnt=%0d required 0/0/0/0/0",
               bus.imem_req, bus.pc, bus.instr_valid, bus.instr, bus.retired_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 32'h0;
    m_cnt = 32'h0;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL boot_no_req: imem_req=%b required 0", bus.imem_req);
    end
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL boot_fetch: req=%b addr=%h required 1/00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  // one instruction: wait for request, stall ack, capture, stall retire, retire with given decode
  task automatic xact(input logic [31:0] w, input logic b_eq, input logic b_ne, input logic jmp,
                      input logic z, input int ack_dly, input int rdy_dly, input logic stray);
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      failures++;
      $display("FAIL req_wait: imem_req=%b required 1", bus.imem_req);
    end
    checks++;
    if (bus.imem_addr !== m_pc || bus.pc_plus4 !== m_pc + 32'd4) begin
      failures++;
      $display("FAIL fetch_addr: addr=%h pc_plus4=%h required %h/%h", bus.imem_addr, bus.pc_plus4, m_pc, m_pc + 32'd4);
    end
    for (int i = 0; i < ack_dly; i++) begin
      bus.instr_ready = stray;
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || bus.instr_valid !== 1'b0 || bus.retired_cnt !== m_cnt) begin
        failures++;
        $display("FAIL fetch_stall: req=%b addr=%h valid=%b cnt=%0d required 1/%h/0/%0d",
                 bus.imem_req, bus.imem_addr, bus.instr_valid, bus.retired_cnt, m_pc, m_cnt);
      end
    end
    bus.instr_ready = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = w;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.imem_rdata = $urandom;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== w || bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL capture: valid=%b instr=%h req=%b required 1/%h/0", bus.instr_valid, bus.instr, bus.imem_req, w);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      bus.imem_ack = stray && i == 0;
      bus.imem_rdata = ~w;
      bus.beq = 1'($urandom);
      bus.bne = 1'($urandom);
      bus.jump = 1'($urandom);
      bus.alu_zero = 1'($urandom);
      @(negedge clk);
      bus.imem_ack = 1'b0;
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== w || bus.imem_req !== 1'b0 ||
          bus.retired_cnt !== m_cnt || bus.pc !== m_pc) begin
        failures++;
        $display("FAIL hold_stall: valid=%b instr=%h req=%b cnt=%0d pc=%h required 1/%h/0/%0d/%h",
                 bus.instr_valid, bus.instr, bus.imem_req, bus.retired_cnt, bus.pc, w, m_cnt, m_pc);
      end
    end
    bus.instr_ready = 1'b1;
    bus.beq = b_eq;
    bus.bne = b_ne;
    bus.jump = jmp;
    bus.alu_zero = z;
    @(negedge clk);
    idle_inputs();
    m_pc = ref_npc(m_pc, w, b_eq, b_ne, jmp, z);
    m_cnt = m_cnt + 32'd1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || bus.retired_cnt !== m_cnt) begin
      failures++;
      $display("FAIL retire: valid=%b req=%b addr=%h cnt=%0d required 0/1/%h/%0d",
               bus.instr_valid, bus.imem_req, bus.imem_addr, bus.retired_cnt, m_pc, m_cnt);
    end
  endtask

  task automatic expect_addr(input string name, input logic [31:0] exp);
    checks++;
    if (bus.imem_addr !== exp) begin
      failures++;
      $display("FAIL %s: imem_addr=%h required %h", name, bus.imem_addr, exp);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    xact($urandom, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.pc !== 32'h0 || bus.instr_valid !== 1'b0 || bus.retired_cnt !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: req=%b pc=%h valid=%b cnt=%0d required 0/0/0/0",
               bus.imem_req, bus.pc, bus.instr_valid, bus.retired_cnt);
    end
    apply_reset();
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int i = 0; i < 3; i++) xact($urandom, 0, 0, 0, 0, 0, 0, 0);
    expect_addr("seq_addr", 32'hC);
    checks++;
    if (bus.retired_cnt !== 32'd3) begin
      failures++;
      $display("FAIL seq_count: retired_cnt=%0d required 3", bus.retired_cnt);
    end
  endtask

  task automatic test_branch();
    xact({6'h02, 26'h10}, 0, 0, 1, 0, 0, 0, 0);
    expect_addr("jump_to_40", 32'h40);
    xact({16'h1000, 16'hFFFE}, 1, 0, 0, 1, 0, 1, 0);
    expect_addr("beq_taken", 32'h3C);
    xact({6'h02, 26'h10}, 0, 0, 1, 0, 0, 0, 0);
    xact({16'h1000, 16'hFFFE}, 1, 0, 0, 0, 1, 0, 0);
    expect_addr("beq_not_taken", 32'h44);
    xact({6'h02, 26'h10}, 0, 0, 1, 0, 0, 0, 0);
    xact({16'h1400, 16'h0003}, 0, 1, 0, 0, 0, 0, 0);
    expect_addr("bne_taken", 32'h50);
    xact({16'h1000, 16'h0001}, 1, 1, 0, 1, 0, 0, 0);
    expect_addr("beq_bne_both", 32'h58);
  endtask

  task automatic test_jump();
    xact({6'h02, 26'h3FF_FFFF}, 0, 0, 1, 0, 0, 0, 0);
    expect_addr("jump_top", 32'h0FFF_FFFC);
    xact($urandom & 32'h03FF_FFFF, 0, 0, 0, 0, 0, 0, 0);
    expect_addr("seq_region", 32'h1000_0000);
    xact({6'h02, 26'h4}, 0, 0, 1, 0, 0, 0, 0);
    expect_addr("jump_region", 32'h1000_0010);
    xact({6'h02, 26'h000_0040}, 1, 0, 1, 1, 1, 1, 0);
    expect_addr("jump_beats_beq", 32'h1000_0100);
  endtask

  task automatic test_stalls();
    xact($urandom, 0, 0, 0, 0, 3, 2, 1);
    expect_addr("stall_seq", 32'h1000_0104);
    xact({16'h1000, 16'h0010}, 1, 0, 0, 1, 3, 2, 1);
    expect_addr("stall_branch", 32'h1000_0148);
    checks++;
    if (bus.retired_cnt !== m_cnt) begin
      failures++;
      $display("FAIL stall_count: retired_cnt=%0d required %0d", bus.retired_cnt, m_cnt);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    xact({16'h1000, 16'hFFFE}, 1, 0, 0, 1, 0, 0, 0);
    expect_addr("to_top", 32'hFFFF_FFFC);
    xact($urandom, 0, 0, 0, 0, 0, 0, 0);
    expect_addr("wrap_zero", 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      xact($urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
           $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stalls();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
